// File: rtl/multicycle_control.sv
// Multicycle sequencer for the RV32I-subset core.
// One ULA and one unified memory are shared across fetch, address, execute
// and branch-compare steps. Stalls on mem_ready and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       OP,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ULAControl,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             is_lb, is_sb, is_r, is_i, is_beq;
  logic             pc_write, ir_write, mem_write, reg_write, trap_flag;

  // Map funct3 to the ULA operation shared by register and immediate forms.
  function automatic logic [2:0] alu_from_f3(input logic [2:0] f3);
    logic [2:0] op;
    op = 3'b000;
    case (f3)
      3'b000:  op = 3'b000;
      3'b111:  op = 3'b010;
      3'b110:  op = 3'b011;
      3'b010:  op = 3'b101;
      3'b100:  op = 3'b110;
      3'b001:  op = 3'b111;
      3'b101:  op = 3'b100;
      default: op = 3'b000;
    endcase
    return op;
  endfunction

  // Classify the IR fields into the supported instruction groups.
  always_comb begin
    is_lb  = (OP == OP_LOAD)   && (Funct3 == 3'b000);
    is_sb  = (OP == OP_STORE)  && (Funct3 == 3'b000);
    is_beq = (OP == OP_BRANCH) && (Funct3 == 3'b000);
    is_r   = (OP == OP_RTYPE) &&
             (((Funct7 == 7'b0000000) && (Funct3 != 3'b011)) ||
              ((Funct7 == 7'b0100000) && (Funct3 == 3'b000)));
    is_i   = (OP == OP_ITYPE) && (Funct3 != 3'b010) && (Funct3 != 3'b011);
  end

  // Next-state sequencing, including memory stalls and the sticky trap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_lb || is_sb)  state_d = S_MEMADR;
        else if (is_r)       state_d = S_EXECUTER;
        else if (is_i)       state_d = S_EXECUTEI;
        else if (is_beq)     state_d = S_BEQ;
        else                 state_d = S_TRAP;
      end
      S_MEMADR:   state_d = is_lb ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // An instruction retires on every completing step that returns to fetch.
  always_comb begin
    count_d = count_q;
    if ((state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
        ((state_q == S_MEMWRITE) && mem_ready))
      count_d = count_q + CNT_W'(1);
  end

  // Datapath control word as a function of the current step and IR fields.
  always_comb begin
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ULASrcA    = 2'b00;
    ULASrcB    = 2'b00;
    ULAControl = 3'b000;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    trap_flag  = 1'b0;
    if (OP == OP_STORE)       ImmSrc = 2'b01;
    else if (OP == OP_BRANCH) ImmSrc = 2'b10;
    else                      ImmSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        ULASrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        ULASrcA = 2'b01;
        ULASrcB = 2'b01;
      end
      S_MEMADR: begin
        ULASrcA = 2'b10;
        ULASrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ULASrcA    = 2'b10;
        ULAControl = (Funct7 == 7'b0100000) ? 3'b001 : alu_from_f3(Funct3);
      end
      S_EXECUTEI: begin
        ULASrcA    = 2'b10;
        ULASrcB    = 2'b01;
        ULAControl = alu_from_f3(Funct3);
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        ULASrcA    = 2'b10;
        ULAControl = 3'b001;
        pc_write   = Zero;
      end
      S_TRAP:     trap_flag = 1'b1;
      default:    trap_flag = 1'b1;
    endcase
  end

  assign PCWrite     = pc_write  & rst_n;
  assign IRWrite     = ir_write  & rst_n;
  assign MemWrite    = mem_write & rst_n;
  assign RegWrite    = reg_write & rst_n;
  assign illegal     = trap_flag & rst_n;
  assign instr_count = count_q;

  // State and retire-counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control (4-bit retire counter).
// Each instruction is expanded into its expected per-cycle control words
// from a table of legal instructions; a monitor compares them cycle by cycle.
module tb_multicycle_control;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LB = 3'd2, C_SB = 3'd3,
                         C_BEQ = 3'd4, C_BAD = 3'd5;

  typedef struct packed {
    logic       pcWrite;
    logic       adrSrc;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [1:0] immSrc;
    logic [2:0] aluCtl;
    logic       illegal;
    logic [3:0] count;
  } obs_t;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7Any;
    logic [2:0] cls;
    logic [2:0] alu;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] OP;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       Zero, mem_ready;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ULASrcA, ULASrcB, ImmSrc;
  logic [2:0] ULAControl;
  logic [3:0] instr_count;

  obs_t   expQ[$];
  string  tagQ[$];
  entry_t instrTable[$];
  int     compared = 0;
  int     mismatched = 0;
  int     retired = 0;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .Funct3(Funct3), .Funct7(Funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
    .ImmSrc(ImmSrc), .ULAControl(ULAControl), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [1:0] immFor(input logic [6:0] op);
    if (op == OP_STORE)  return 2'b01;
    if (op == OP_BRANCH) return 2'b10;
    return 2'b00;
  endfunction

  function automatic obs_t blank();
    obs_t o;
    o = '0;
    o.immSrc = immFor(OP);
    o.count  = 4'(retired % 16);
    return o;
  endfunction

  function automatic obs_t fetchWord();
    obs_t o;
    o = blank();
    o.srcB = 2'b10;
    o.resultSrc = 2'b10;
    return o;
  endfunction

  function automatic entry_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic any,
                                input logic [2:0] cls, input logic [2:0] alu);
    entry_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.f7Any = any; e.cls = cls; e.alu = alu;
    return e;
  endfunction

  task automatic buildTable();
    instrTable.push_back(mk(OP_RTYPE, 3'b000, 7'b0000000, 0, C_R, 3'b000));
    instrTable.push_back(mk(OP_RTYPE, 3'b000, 7'b0100000, 0, C_R, 3'b001));
    instrTable.push_back(mk(OP_RTYPE, 3'b111, 7'b0000000, 0, C_R, 3'b010));
    instrTable.push_back(mk(OP_RTYPE, 3'b110, 7'b0000000, 0, C_R, 3'b011));
    instrTable.push_back(mk(OP_RTYPE, 3'b010, 7'b0000000, 0, C_R, 3'b101));
    instrTable.push_back(mk(OP_RTYPE, 3'b100, 7'b0000000, 0, C_R, 3'b110));
    instrTable.push_back(mk(OP_RTYPE, 3'b001, 7'b0000000, 0, C_R, 3'b111));
    instrTable.push_back(mk(OP_RTYPE, 3'b101, 7'b0000000, 0, C_R, 3'b100));
    instrTable.push_back(mk(OP_ITYPE, 3'b000, 7'b0, 1, C_I, 3'b000));
    instrTable.push_back(mk(OP_ITYPE, 3'b111, 7'b0, 1, C_I, 3'b010));
    instrTable.push_back(mk(OP_ITYPE, 3'b110, 7'b0, 1, C_I, 3'b011));
    instrTable.push_back(mk(OP_ITYPE, 3'b100, 7'b0, 1, C_I, 3'b110));
    instrTable.push_back(mk(OP_ITYPE, 3'b001, 7'b0, 1, C_I, 3'b111));
    instrTable.push_back(mk(OP_ITYPE, 3'b101, 7'b0, 1, C_I, 3'b100));
    instrTable.push_back(mk(OP_LOAD,   3'b000, 7'b0, 1, C_LB,  3'b000));
    instrTable.push_back(mk(OP_STORE,  3'b000, 7'b0, 1, C_SB,  3'b000));
    instrTable.push_back(mk(OP_BRANCH, 3'b000, 7'b0, 1, C_BEQ, 3'b000));
  endtask

  // Look up the instruction; anything not in the table is illegal.
  task automatic classify(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, output logic [2:0] cls,
                          output logic [2:0] alu);
    cls = C_BAD;
    alu = 3'b000;
    foreach (instrTable[i]) begin
      if (instrTable[i].op == op && instrTable[i].f3 == f3 &&
          (instrTable[i].f7Any || instrTable[i].f7 == f7)) begin
        cls = instrTable[i].cls;
        alu = instrTable[i].alu;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the control word expected for it.
  task automatic applyStimulus(input obs_t exp, input string tag,
                               input logic ready, input logic zero);
    mem_ready = ready;
    Zero = zero;
    expQ.push_back(exp);
    tagQ.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Hold reset low for one cycle, checking the forced outputs, then release.
  task automatic resetStep();
    obs_t e;
    rst_n = 1'b0;
    OP = 7'($urandom);
    retired = 0;
    e = fetchWord();
    applyStimulus(e, "reset", rb(), rb());
    rst_n = 1'b1;
  endtask

  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input int fetchWait,
                          input int memWait, input logic zero,
                          input logic abortMem);
    obs_t e;
    logic [2:0] cls, alu;
    OP = op; Funct3 = f3; Funct7 = f7;
    classify(op, f3, f7, cls, alu);
    for (int k = 0; k < fetchWait; k++) applyStimulus(fetchWord(), "fetch-wait", 1'b0, rb());
    e = fetchWord(); e.irWrite = 1'b1; e.pcWrite = 1'b1;
    applyStimulus(e, "fetch", 1'b1, rb());
    e = blank(); e.srcA = 2'b01; e.srcB = 2'b01;
    applyStimulus(e, "decode", rb(), rb());
    case (cls)
      C_R, C_I: begin
        e = blank(); e.srcA = 2'b10; e.srcB = (cls == C_I) ? 2'b01 : 2'b00; e.aluCtl = alu;
        applyStimulus(e, "execute", rb(), rb());
        e = blank(); e.regWrite = 1'b1;
        applyStimulus(e, "aluwb", rb(), rb());
        retired++;
      end
      C_LB, C_SB: begin
        e = blank(); e.srcA = 2'b10; e.srcB = 2'b01;
        applyStimulus(e, "memadr", rb(), rb());
        e = blank(); e.adrSrc = 1'b1; e.memWrite = (cls == C_SB);
        for (int k = 0; k < memWait; k++) applyStimulus(e, "mem-wait", 1'b0, rb());
        if (abortMem) begin
          resetStep();
          return;
        end
        applyStimulus(e, "mem-done", 1'b1, rb());
        if (cls == C_SB) retired++;
        else begin
          e = blank(); e.resultSrc = 2'b01; e.regWrite = 1'b1;
          applyStimulus(e, "memwb", rb(), rb());
          retired++;
        end
      end
      C_BEQ: begin
        e = blank(); e.srcA = 2'b10; e.aluCtl = 3'b001; e.pcWrite = zero;
        applyStimulus(e, "beq", rb(), zero);
        retired++;
      end
      default: begin
        e = blank(); e.illegal = 1'b1;
        for (int k = 0; k < 3; k++) applyStimulus(e, "trap", rb(), rb());
        resetStep();
      end
    endcase
  endtask

  // Compare the DUT outputs against one queued expectation.
  task automatic checkOutput();
    obs_t exp, act;
    string tag;
    exp = expQ.pop_front();
    tag = tagQ.pop_front();
    act = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ULASrcA,
           ULASrcB, ImmSrc, ULAControl, illegal, instr_count};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s (OP=%b F3=%b F7=%b): actual=%b required=%b",
               tag, OP, Funct3, Funct7, act, exp);
    end
  endtask

  // Monitor: mid-cycle, check whenever an expectation is pending.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput();
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [6:0] op, f7;
    logic [2:0] f3;
    int pick;
    rst_n = 1'b0; OP = '0; Funct3 = '0; Funct7 = '0; Zero = 1'b0; mem_ready = 1'b0;
    buildTable();
    @(posedge clk);
    #1;
    resetStep();
    $display("[TB] directed sequence");
    runInstr(OP_RTYPE,  3'b000, 7'b0000000, 0, 0, 1'b0, 1'b0);
    runInstr(OP_LOAD,   3'b000, 7'b0000000, 0, 3, 1'b0, 1'b0);
    runInstr(OP_STORE,  3'b000, 7'b0000000, 0, 2, 1'b0, 1'b0);
    runInstr(OP_BRANCH, 3'b000, 7'b0000000, 0, 0, 1'b1, 1'b0);
    runInstr(OP_BRANCH, 3'b000, 7'b0000000, 0, 0, 1'b0, 1'b0);
    runInstr(OP_STORE,  3'b000, 7'b0000000, 1, 2, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) runInstr(OP_ITYPE, 3'b000, 7'b1111111, 0, 0, 1'b0, 1'b0);
    runInstr(OP_RTYPE,  3'b000, 7'b0000001, 0, 0, 1'b0, 1'b0);
    $display("[TB] random sequence");
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        pick = $urandom_range(0, instrTable.size() - 1);
        op = instrTable[pick].op;
        f3 = instrTable[pick].f3;
        f7 = instrTable[pick].f7Any ? 7'($urandom) : instrTable[pick].f7;
      end else begin
        case ($urandom_range(0, 3))
          0: op = OP_RTYPE;
          1: op = OP_ITYPE;
          2: op = OP_LOAD;
          default: op = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        f7 = rb() ? 7'b0000000 : 7'($urandom);
      end
      runInstr(op, f3, f7, $urandom_range(0, 2), $urandom_range(0, 3), rb(),
               ($urandom_range(0, 19) == 0));
    end
    for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clk);
    if (expQ.size() > 0) begin
      mismatched++;
      $display("[TB] FAIL drain: pending=%0d required=0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the RV32I-subset core. It replaces single-cycle decode with an FSM that shares one ULA and one unified instruction/data memory across fetch, address, execute and branch-compare steps.
- Sits between the instruction register (IR) fields and the datapath muxes and enables.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- OP  in  7  opcode field of the IR
- Funct3  in  3  funct3 field of the IR
- Funct7  in  7  funct7 field of the IR
- Zero  in  1  ULA zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ULAOut
- IRWrite  out  1  IR/OldPC load enable
- MemWrite  out  1  memory write strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00 = ULAOut, 01 = Data, 10 = ULA result
- ULASrcA  out  2  A mux: 00 = PC, 01 = OldPC, 10 = rs1
- ULASrcB  out  2  B mux: 00 = rs2, 01 = Imm, 10 = constant 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B
- ULAControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 xor, 111 sll, 100 srl
- illegal  out  1  high in TRAP
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low, asynchronous): state = FETCH, instr_count = 0. While rst_n is low, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0. All other outputs take their FETCH values.
- Outputs are combinational from state, OP, Funct3, Funct7, Zero and mem_ready. Any mux select not listed for a state is 00. ULAControl defaults to 000 (add).
- ImmSrc depends on OP in every state: 0100011 -> 01, 1100011 -> 10, otherwise 00.
- FETCH:
  - AdrSrc=0, ULASrcA=00, ULASrcB=10, add, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ULASrcA=01, ULASrcB=01, add (precomputes the branch target into ULAOut).
  - Next state:
    - OP 0000011 with Funct3 000 (LB), or OP 0100011 with Funct3 000 (SB) -> MEMADR.
    - OP 0110011 with a legal funct (see below) -> EXECUTER.
    - OP 0010011 with Funct3 in {000, 111, 110, 100, 001, 101} -> EXECUTEI.
    - OP 1100011 with Funct3 000 -> BEQ.
    - Anything else -> TRAP.
- MEMADR: ULASrcA=10, ULASrcB=01, add. Go to MEMREAD for LB, MEMWRITE for SB.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held asserted until mem_ready=1, then FETCH.
- EXECUTER: ULASrcA=10, ULASrcB=00. Go to ALUWB.
  - Funct7 0000000: Funct3 000 add, 111 and, 110 or, 010 slt, 100 xor, 001 sll, 101 srl.
  - Funct7 0100000 with Funct3 000: sub.
  - Any other funct combination was already routed to TRAP in DECODE.
- EXECUTEI: ULASrcA=10, ULASrcB=01. Go to ALUWB.
  - ULAControl from Funct3: 000 add, 111 and, 110 or, 100 xor, 001 sll, 101 srl.
  - Funct7 is ignored.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ULASrcA=10, ULASrcB=00, sub, ResultSrc=00. PCWrite = Zero. Then FETCH.
- TRAP: illegal=1, all enables 0. Remains in TRAP until reset.
- Retire counter:
  - instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (mem_ready=1), ALUWB or BEQ.
  - Wraps modulo 2^CNT_W. Never increments in FETCH, DECODE or TRAP.
- Mid-operation reset: an asynchronous drop of rst_n in any state (including while MemWrite is held) returns to FETCH immediately with all enables 0.
- IR fields are stable from the end of FETCH until the next FETCH completes, so decode may use them in any state.
- Latency, in cycles with mem_ready always 1: R-type/I-ALU 4, LB 5, SB 4, BEQ 3.

Test Plan:
- ADD (OP 0110011, F3 000, F7 0000000), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB; ULAControl=000 in EXECUTER; RegWrite=1 only in ALUWB; instr_count 0 -> 1.
- LB with mem_ready=0 for 3 cycles in MEMREAD -> AdrSrc=1 held for 4 cycles, then MEMWB with ResultSrc=01 and RegWrite=1; total 8 cycles.
- SB with mem_ready low 2 cycles -> MemWrite=1 for exactly 3 cycles, then FETCH; instr_count +1.
- BEQ twice: Zero=1 -> PCWrite=1 in BEQ with ULAControl=001; Zero=0 -> PCWrite=0.
- OP 0110011, F3 000, F7 0000001 -> TRAP, illegal=1, no further enables; rst_n pulse low returns to FETCH with instr_count=0.
- Preload instr_count to all-ones (CNT_W=4, 15 retires), retire one more -> wraps to 0.
